// File: rtl/mem_arbiter.sv
// Round-robin sharing of one cache-line memory controller between NUM_REQ requesters.
// Grant one cycle after an eligible request in IDLE; owner holds the controller until mc_tx_done.
module mem_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [2*NUM_REQ-1:0]             req_op,
    input  logic [ADDR_BITCOUNT*NUM_REQ-1:0] req_addr,
    input  logic [WORD_SIZE*NUM_REQ-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]               req_grant,
    output logic [NUM_REQ-1:0]               req_wnext,
    output logic [NUM_REQ-1:0]               req_rd_valid,
    output logic [WORD_SIZE-1:0]             req_rdata,
    output logic [NUM_REQ-1:0]               req_done,
    input  logic                             mc_ready,
    output logic [1:0]                       mc_op,
    output logic [ADDR_BITCOUNT-1:0]         mc_raw_address,
    output logic [WORD_SIZE-1:0]             mc_wdata,
    input  logic [WORD_SIZE-1:0]             mc_rdata,
    input  logic                             mc_rd_valid,
    input  logic                             mc_tx_done,
    output logic                             busy
);
    localparam int FILL_COUNT = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int IW         = $clog2(NUM_REQ);
    localparam int CW         = $clog2(FILL_COUNT + 2);
    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACTIVE} state_t;

    state_t                   state;
    logic [NUM_REQ-1:0]       grant_q;
    logic [1:0]               op_q;
    logic [ADDR_BITCOUNT-1:0] addr_q;
    logic [IW-1:0]            last_q;
    logic [CW-1:0]            wcnt_q;

    logic [NUM_REQ-1:0]       eligible;
    logic                     pick_vld;
    logic [IW-1:0]            pick_idx;
    int                       cand;
    logic                     active;
    logic                     wnext_win;
    logic [WORD_SIZE-1:0]     wdata_mux;

    // Ops 01 and 11 both have bit 0 set; 00 and 10 never request.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & req_op[2*i];
        end
    end

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_q) + k) % NUM_REQ;
            if (!pick_vld && eligible[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            grant_q <= '0;
            op_q    <= OP_IDLE;
            addr_q  <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            wcnt_q  <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (mc_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (pick_vld) begin
                        state   <= ST_ACTIVE;
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        op_q    <= req_op[2*int'(pick_idx) +: 2];
                        addr_q  <= req_addr[ADDR_BITCOUNT*int'(pick_idx) +: ADDR_BITCOUNT];
                        last_q  <= pick_idx;
                        wcnt_q  <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (wcnt_q != CW'(FILL_COUNT + 1)) begin
                        wcnt_q <= wcnt_q + CW'(1);
                    end
                    if (mc_tx_done) begin
                        state   <= ST_IDLE;
                        grant_q <= '0;
                        op_q    <= OP_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Controller samples the op on the first ACTIVE cycle, then eats one word per cycle.
    assign active    = (state == ST_ACTIVE);
    assign wnext_win = active && (op_q == OP_WRITE) &&
                       (wcnt_q >= CW'(1)) && (wcnt_q <= CW'(FILL_COUNT));

    always_comb begin
        wdata_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                wdata_mux = wdata_mux | req_wdata[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign req_grant      = grant_q;
    assign req_wnext      = grant_q & {NUM_REQ{wnext_win}};
    assign req_rd_valid   = grant_q & {NUM_REQ{active && (op_q == OP_READ) && mc_rd_valid}};
    assign req_done       = grant_q & {NUM_REQ{active && mc_tx_done}};
    assign req_rdata      = mc_rdata;
    assign mc_op          = op_q;
    assign mc_raw_address = addr_q;
    assign mc_wdata       = wdata_mux;
    assign busy           = active;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int CL = 512;
    localparam int AW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_op;
    logic [AW*NR-1:0]  req_addr;
    logic [W*NR-1:0]   req_wdata;
    logic [NR-1:0]     req_grant, req_wnext, req_rd_valid, req_done;
    logic [W-1:0]      req_rdata;
    logic              mc_ready;
    logic [1:0]        mc_op;
    logic [AW-1:0]     mc_raw_address;
    logic [W-1:0]      mc_wdata, mc_rdata;
    logic              mc_rd_valid, mc_tx_done, busy;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.NUM_REQ(NR), .WORD_SIZE(W), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_grant(req_grant), .req_wnext(req_wnext), .req_rd_valid(req_rd_valid),
        .req_rdata(req_rdata), .req_done(req_done),
        .mc_ready(mc_ready), .mc_op(mc_op), .mc_raw_address(mc_raw_address),
        .mc_wdata(mc_wdata), .mc_rdata(mc_rdata), .mc_rd_valid(mc_rd_valid),
        .mc_tx_done(mc_tx_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [AW-1:0] a);
        req_valid[i]         = v;
        req_op[2*i +: 2]     = op;
        req_addr[AW*i +: AW] = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mc_ready = 1'b0; mc_rd_valid = 1'b0; mc_tx_done = 1'b0;
        req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0; mc_rdata = '0;
        set_req(0, 1'b1, 2'b01, 64'hA000);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_grant !== 4'b0) begin errors++; $display("FAIL reset_grant got %b want 0000", req_grant); end
        checks++; if (mc_op !== 2'b00) begin errors++; $display("FAIL reset_mc_op got %b want 00", mc_op); end
        checks++; if (mc_raw_address !== 64'h0) begin errors++; $display("FAIL reset_addr got %h want 0", mc_raw_address); end
        checks++; if ({busy, req_done, req_wnext, req_rd_valid} !== 13'h0) begin errors++; $display("FAIL reset_outputs got %b want 0", {busy, req_done, req_wnext, req_rd_valid}); end
        checks++; if (mc_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", mc_wdata); end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            checks++; if (req_grant !== 4'b0 || mc_op !== 2'b00) begin errors++; $display("FAIL startup_gate cyc %0d got grant %b op %b want 0000 00", k, req_grant, mc_op); end
        end
        @(negedge clk); mc_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (req_grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL startup_idle got grant %b busy %b want 0000 0", req_grant, busy); end
        @(negedge clk); #1;
        checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL startup_grant got %b want 0001", req_grant); end
        checks++; if (mc_op !== 2'b01 || mc_raw_address !== 64'hA000) begin errors++; $display("FAIL startup_op got %b %h want 01 a000", mc_op, mc_raw_address); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL startup_busy got %b want 1", busy); end
        mc_tx_done = 1'b1; set_req(0, 1'b0, 2'b01, 64'hA000); #1;
        checks++; if (req_done !== 4'b0001) begin errors++; $display("FAIL startup_done got %b want 0001", req_done); end
        @(negedge clk); mc_tx_done = 1'b0; #1;
        checks++; if (req_grant !== 4'b0 || mc_op !== 2'b00) begin errors++; $display("FAIL startup_release got %b %b want 0000 00", req_grant, mc_op); end
    endtask

    task automatic test_read();
        int nvld = 0;
        set_req(2, 1'b1, 2'b01, 64'hB200);
        mc_rd_valid = 1'b1; mc_tx_done = 1'b1; #1;
        checks++; if (req_rd_valid !== 4'b0 || req_done !== 4'b0) begin errors++; $display("FAIL read_idle_ignore got %b %b want 0000 0000", req_rd_valid, req_done); end
        @(negedge clk); mc_rd_valid = 1'b0; mc_tx_done = 1'b0; set_req(2, 1'b0, 2'b01, 64'hB200); #1;
        checks++; if (req_grant !== 4'b0100 || mc_op !== 2'b01 || mc_raw_address !== 64'hB200) begin errors++; $display("FAIL read_grant got %b %b %h want 0100 01 b200", req_grant, mc_op, mc_raw_address); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); mc_rd_valid = 1'b1; mc_rdata = 32'h100 + k; #1;
            if (req_rd_valid === 4'b0100) nvld++;
            checks++; if (req_rd_valid !== 4'b0100 || req_rdata !== 32'h100 + k || req_wnext !== 4'b0) begin errors++; $display("FAIL read_word %0d got %b %h want 0100 %h", k, req_rd_valid, req_rdata, 32'h100 + k); end
        end
        @(negedge clk); mc_rd_valid = 1'b0; mc_tx_done = 1'b1; #1;
        checks++; if (nvld !== 16) begin errors++; $display("FAIL read_count got %0d want 16", nvld); end
        checks++; if (req_done !== 4'b0100 || req_rd_valid !== 4'b0) begin errors++; $display("FAIL read_done got %b %b want 0100 0000", req_done, req_rd_valid); end
        @(negedge clk); mc_tx_done = 1'b0; #1;
        checks++; if (req_grant !== 4'b0 || mc_op !== 2'b00 || req_done !== 4'b0) begin errors++; $display("FAIL read_release got %b %b %b want 0000 00 0000", req_grant, mc_op, req_done); end
    endtask

    task automatic test_write();
        int wc = 0;
        logic exp_wn;
        set_req(1, 1'b1, 2'b11, 64'hC100);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) set_req(1, 1'b0, 2'b11, 64'hC100);
            req_wdata[W*1 +: W] = 32'hD000 + wc;
            mc_tx_done = (c == 20);
            #1;
            exp_wn = (c >= 2 && c <= 17);
            if (c == 1) begin
                checks++; if (req_grant !== 4'b0010 || mc_op !== 2'b11 || mc_raw_address !== 64'hC100) begin errors++; $display("FAIL write_grant got %b %b %h want 0010 11 c100", req_grant, mc_op, mc_raw_address); end
            end
            checks++; if (req_wnext !== (exp_wn ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL write_wnext cyc %0d got %b want %b", c, req_wnext, exp_wn ? 4'b0010 : 4'b0000); end
            checks++; if (mc_wdata !== 32'hD000 + wc) begin errors++; $display("FAIL write_data cyc %0d got %h want %h", c, mc_wdata, 32'hD000 + wc); end
            if (req_wnext[1] === 1'b1) wc++;
            if (c == 20) begin
                checks++; if (req_done !== 4'b0010) begin errors++; $display("FAIL write_done got %b want 0010", req_done); end
            end
        end
        checks++; if (wc !== 16) begin errors++; $display("FAIL write_count got %0d want 16", wc); end
        @(negedge clk); mc_tx_done = 1'b0; #1;
        checks++; if (req_grant !== 4'b0 || mc_wdata !== 32'h0) begin errors++; $display("FAIL write_release got %b %h want 0000 0", req_grant, mc_wdata); end
    endtask

    task automatic test_stability_invalid();
        set_req(0, 1'b1, 2'b10, 64'hA0A0);
        set_req(3, 1'b1, 2'b01, 64'hE300);
        @(negedge clk); set_req(3, 1'b0, 2'b01, 64'hFFFF0000); #1;
        checks++; if (req_grant !== 4'b1000) begin errors++; $display("FAIL stab_grant got %b want 1000", req_grant); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); mc_rd_valid = 1'b1; mc_rdata = k; #1;
            checks++; if (mc_op !== 2'b01 || mc_raw_address !== 64'hE300 || req_rd_valid !== 4'b1000) begin errors++; $display("FAIL stab_hold %0d got %b %h %b want 01 e300 1000", k, mc_op, mc_raw_address, req_rd_valid); end
        end
        @(negedge clk); mc_rd_valid = 1'b0; mc_tx_done = 1'b1; #1;
        checks++; if (req_done !== 4'b1000) begin errors++; $display("FAIL stab_done got %b want 1000", req_done); end
        @(negedge clk); mc_tx_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            checks++; if (req_grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL invalid_op_grant %0d got %b %b want 0000 0", k, req_grant, busy); end
        end
    endtask

    task automatic test_reset_midwrite();
        int wc = 0;
        set_req(2, 1'b1, 2'b11, 64'hC200);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            req_wdata[W*2 +: W] = 32'hE000 + wc;
            if (c == 9) begin rst_n = 1'b0; mc_ready = 1'b0; end
            #1;
            if (c == 1) begin
                checks++; if (req_grant !== 4'b0100 || mc_op !== 2'b11) begin errors++; $display("FAIL rstw_grant got %b %b want 0100 11", req_grant, mc_op); end
            end
            if (c == 9) begin
                checks++; if (wc !== 7) begin errors++; $display("FAIL rstw_words got %0d want 7", wc); end
            end
            if (req_wnext[2] === 1'b1) wc++;
        end
        @(negedge clk); #1;
        checks++; if (req_grant !== 4'b0 || mc_op !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rstw_abort got %b %b %b want 0000 00 0", req_grant, mc_op, busy); end
        checks++; if (req_done !== 4'b0 || req_wnext !== 4'b0 || mc_raw_address !== 64'h0) begin errors++; $display("FAIL rstw_outputs got %b %b %h want 0000 0000 0", req_done, req_wnext, mc_raw_address); end
        rst_n = 1'b1;
        set_req(0, 1'b1, 2'b01, 64'hA111);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++; if (req_grant !== 4'b0) begin errors++; $display("FAIL rstw_init %0d got %b want 0000", k, req_grant); end
        end
        mc_ready = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (req_grant !== 4'b0001 || mc_raw_address !== 64'hA111) begin errors++; $display("FAIL rstw_first got %b %h want 0001 a111", req_grant, mc_raw_address); end
        mc_tx_done = 1'b1; req_valid = '0;
        @(negedge clk); mc_tx_done = 1'b0;
    endtask

    task automatic test_round_robin();
        int dcnt [NR];
        logic [NR-1:0] exp_g;
        for (int i = 0; i < NR; i++) dcnt[i] = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; mc_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 2'b01, 64'h5000 + 64'(i));
        @(negedge clk); #1;
        checks++; if (req_grant !== 4'b0) begin errors++; $display("FAIL rr_idle got %b want 0000", req_grant); end
        for (int g = 0; g < 5; g++) begin
            exp_g = 4'b0001 << (g % NR);
            @(negedge clk); mc_tx_done = 1'b1; #1;
            checks++; if (req_grant !== exp_g || req_done !== exp_g) begin errors++; $display("FAIL rr_grant %0d got %b %b want %b", g, req_grant, req_done, exp_g); end
            checks++; if (mc_raw_address !== 64'h5000 + 64'(g % NR)) begin errors++; $display("FAIL rr_addr %0d got %h want %h", g, mc_raw_address, 64'h5000 + 64'(g % NR)); end
            for (int i = 0; i < NR; i++) if (req_done[i] === 1'b1) dcnt[i]++;
            @(negedge clk); mc_tx_done = 1'b0; #1;
            checks++; if (req_grant !== 4'b0) begin errors++; $display("FAIL rr_gap %0d got %b want 0000", g, req_grant); end
        end
        checks++; if (dcnt[0] !== 2 || dcnt[1] !== 1 || dcnt[2] !== 1 || dcnt[3] !== 1) begin errors++; $display("FAIL rr_done_counts got %0d %0d %0d %0d want 2 1 1 1", dcnt[0], dcnt[1], dcnt[2], dcnt[3]); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_read();
        test_write();
        test_stability_invalid();
        test_reset_midwrite();
        test_round_robin();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached without completing the sequence");
        $fatal(1);
    end
endmodule
